// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine producing the HI/LO pair, one bit per cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle array product instead of RUN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mag_q, mag_d;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   sh_q, sh_d;      // multiplier (shifts right) or dividend (shifts left)
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
`ifdef MULDIV_FAST_MUL_EN
  logic               fast_q, fast_d;
`endif

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum, rsh, dtrial;
  logic               dok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign abs_a = (!op[0] && a[WIDTH-1]) ? neg_w(a) : a;
  assign abs_b = (!op[0] && b[WIDTH-1]) ? neg_w(b) : b;

  assign msum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (sh_q[0] ? {1'b0, mag_q} : '0);

  // Remainder is always below the divisor, so the top trial bit is exactly the borrow.
  assign rsh    = {work_q[2*WIDTH-1:WIDTH], sh_q[WIDTH-1]};
  assign dtrial = rsh - {1'b0, mag_q};
  assign dok    = ~dtrial[WIDTH];

  assign prod_fix = qneg_q ? neg_2w(work_q) : work_q;
  assign quo_fix  = qneg_q ? neg_w(work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? neg_w(work_q[2*WIDTH-1:WIDTH]) : work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mag_d   = mag_q;
    sh_d    = sh_q;
    araw_d  = araw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fast_d  = fast_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          op_d    = op;
          araw_d  = a;
          mag_d   = op[1] ? abs_b : abs_a;
          sh_d    = op[1] ? abs_a : abs_b;
          qneg_d  = ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = ~op[0] & a[WIDTH-1];
          work_d  = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
`ifdef MULDIV_FAST_MUL_EN
          fast_d  = ~op[1];
          if (!op[1]) state_d = S_FIX;
`endif
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            work_d = {(dok ? dtrial[WIDTH-1:0] : rsh[WIDTH-1:0]), work_q[WIDTH-2:0], dok};
            sh_d   = sh_q << 1;
          end else begin
            work_d = {msum, work_q[WIDTH-1:1]};
            sh_d   = sh_q >> 1;
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
`ifdef MULDIV_FAST_MUL_EN
          fast_d  = 1'b0;
        end else if (fast_q) begin
          work_d = {{WIDTH{1'b0}}, mag_q} * {{WIDTH{1'b0}}, sh_q};
          fast_d = 1'b0;
`endif
        end else begin
          if (op_q[1]) begin
            if (mag_q == '0) begin
              hi_d = araw_q;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mag_q   <= '0;
      sh_q    <= '0;
      araw_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      work_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      fast_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mag_q   <= mag_d;
      sh_q    <= sh_d;
      araw_q  <= araw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef MULDIV_FAST_MUL_EN
      fast_q  <= fast_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH = 32): arithmetic, latency, cancel, reset and busy behaviour.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller is positioned at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h0;
    check_val({tag, "_busy"}, 64'(busy), 64'd1);
    for (n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) break;
    end
    check_val({tag, "_lat"}, 64'(n), 64'(lat));
    check_val({tag, "_hi"}, 64'(hi), 64'(eh));
    check_val({tag, "_lo"}, 64'(lo), 64'(el));
    check_val({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int dones;
    dones = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_val({tag, "_no_done"}, 64'(dones), 64'd0);
  endtask

  task automatic cancel_at(input string tag, input int k, input logic [31:0] ph, input logic [31:0] pl);
    start = 1'b1; op = 2'b10; a = 32'hFFFFFFF9; b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val({tag, "_busy_before"}, 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    check_val({tag, "_busy_after"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_hi_kept"}, 64'(hi), 64'(ph));
    check_val({tag, "_lo_kept"}, 64'(lo), 64'(pl));
    expect_no_done(tag, 40);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT);
    @(negedge clk);
    check_val("done_pulse_width", 64'(done), 64'd0);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT);
    run_op("div_m7d2_b2b", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
    run_op("div_7dm2_b2b", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
    @(negedge clk);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, DIV_LAT);
    run_op("div_by0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, DIV_LAT);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT);
    run_op("mult_min_sq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT);
    run_op("mult_7xm1", 2'b00, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, MUL_LAT);

    // A start raised mid-operation must neither disturb nor queue behind the running divide.
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (n = 7; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) break;
    end
    check_val("busy_start_lat", 64'(n), 64'(DIV_LAT));
    check_val("busy_start_hi", 64'(hi), 64'd2);
    check_val("busy_start_lo", 64'(lo), 64'd14);
    expect_no_done("busy_start_not_queued", 40);

    cancel_at("cancel_run10", 10, 32'd2, 32'd14);
    cancel_at("cancel_fix", 32, 32'd2, 32'd14);

    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check_val("start_cancel_idle_busy", 64'(busy), 64'd0);
    expect_no_done("start_cancel_idle", 40);

    start = 1'b1; op = 2'b11; a = 32'hFFFFFFFF; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    check_val("midrun_rst_busy", 64'(busy), 64'd0);
    check_val("midrun_rst_done", 64'(done), 64'd0);
    check_val("midrun_rst_hi", 64'(hi), 64'd0);
    check_val("midrun_rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the execute stage of the pipelined MIPS core. It produces the HI/LO result pair for MULT, MULTU, DIV and DIVU. It replaces single-cycle HI/LO arithmetic with a parametrised-width, multi-cycle engine. While it runs it holds `busy`, which the hazard logic uses to stall the execute stage. It accepts a cancel from the pipeline flush path.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be ≥ 4 and even. `hi` and `lo` are each `WIDTH` bits.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request a new operation. Sampled only in IDLE.
- `op` input 2: operation select. 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
- `a` input WIDTH: multiplicand or dividend (rs). Captured when `start` is accepted.
- `b` input WIDTH: multiplier or divisor (rt). Captured when `start` is accepted.
- `cancel` input 1: abort the operation in flight (execute-stage flush).
- `busy` output 1: high while not in IDLE.
- `done` output 1: one-cycle pulse when `hi` and `lo` are updated.
- `hi` output WIDTH: high product for multiply, remainder for divide. Registered.
- `lo` output WIDTH: low product for multiply, quotient for divide. Registered.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**
  - `start` = 1 and `cancel` = 0:
    - Latch `op`.
    - Latch |a| and |b| (absolute values only for signed ops).
    - Latch the result-sign flags: quotient/product sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
    - Clear the `WIDTH*2`-bit working register.
    - Load the iteration counter with `WIDTH`.
    - Go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, one bit per cycle:
  - Multiply: shift-add, LSB first.
  - Divide: restoring shift-subtract, MSB first. The trial subtraction is `WIDTH+1` bits wide.
  - The counter decrements each cycle. At count 1 the next state is FIX.
- **FIX**
  - Two's-complement negate the product, quotient and/or remainder according to the latched sign flags. This applies to signed ops only.
  - Write the results into `hi`/`lo` and pulse `done`.
  - Return to IDLE.
- Division by zero, signed or unsigned: `lo` = all ones, `hi` = dividend as presented on `a`. Still takes the full latency.
- Signed overflow (−2^(WIDTH−1) / −1): `lo` = −2^(WIDTH−1) (wraps), `hi` = 0.
- `cancel` in RUN or FIX:
  - Next state is IDLE.
  - `hi`/`lo` are unchanged and no `done` pulse is produced.
  - `cancel` has priority over the FIX write-back in the same cycle.
- `cancel` and `start` together in IDLE: the start is ignored.
- `start` while `busy`: ignored, not queued.
- `hi`/`lo` hold the last completed result indefinitely.

## Timing
- Reset values: state = IDLE; `busy` = 0; `done` = 0; `hi` = 0; `lo` = 0; counter = 0; working register = 0. Reset takes effect immediately, including mid-operation, and the partial result is discarded.
- Accept edge T0: `start` is sampled high in IDLE.
- `busy` goes high after T0 and stays high through the FIX cycle.
- Iterative path: RUN occupies edges T0+1 … T0+WIDTH. FIX ends at edge T0+WIDTH+1.
- `done` = 1 and new `hi`/`lo` become visible after edge T0+WIDTH+1. `busy` is 0 in that same cycle.
- Total latency is `WIDTH+1` cycles from acceptance to `done`; 33 cycles for `WIDTH` = 32.
- Back-to-back: a new `start` can be accepted in the cycle `done` is high, i.e. zero idle-cycle gap.
- `busy` is a registered output. The hazard unit ORs it with "op in execute" to form the execute-stage stall.

## Configuration
- `MULDIV_FAST_MUL_EN`
  - Defined: MULT/MULTU skip RUN. They go IDLE → FIX, and the full `WIDTH`×`WIDTH` product is computed combinationally from the latched |a|, |b|. `done` arrives after edge T0+2, a latency of 2 cycles. Divide is unchanged.
  - Undefined: multiply uses the iterative RUN path with the same latency as divide.

## Test plan
All scenarios use `WIDTH` = 32.
- MULT: a = 0xFFFFFFFD (−3), b = 5 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1. `done` after 33 cycles, or 2 cycles with `MULDIV_FAST_MUL_EN`.
- MULTU: a = b = 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- DIV: a = 0xFFFFFFF9 (−7), b = 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. DIVU: a = 100, b = 7 → `lo` = 14, `hi` = 2.
- DIVU: a = 100, b = 0 → `lo` = 0xFFFFFFFF, `hi` = 0x00000064. DIV: a = 0x80000000, b = 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- Cancel: start DIV, assert `cancel` 10 cycles later → `busy` low the next cycle, no `done`, `hi`/`lo` keep the prior result. A `start` during `busy` produces no effect.
- Reset: drive `rst` low mid-RUN → `busy`, `done`, `hi`, `lo` are 0 immediately. After `rst` returns high, a fresh MULTU 6 × 7 gives `lo` = 42.
